// File: rtl/clock_pkg.sv
// Shared definitions for the clock counter bank: FSM state encoding,
// field indices, default limits and auto-repeat timing.
package clock_pkg;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_RUN        = 2'd0;
    localparam state_t S_SET_IDLE   = 2'd1;
    localparam state_t S_SET_HOLD   = 2'd2;
    localparam state_t S_SET_REPEAT = 2'd3;

    // Field indices within the counter bank
    localparam logic [1:0] F_SEC  = 2'd0;
    localparam logic [1:0] F_MIN  = 2'd1;
    localparam logic [1:0] F_HOUR = 2'd2;

    // Default terminal values of each field
    localparam int DEF_LIM0 = 59;
    localparam int DEF_LIM1 = 59;
    localparam int DEF_LIM2 = 23;

    // Default auto-repeat timing, in clock cycles
    localparam int DEF_REPEAT_DELAY  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 5_000_000;

    // Advance the selected field: sec -> min -> hour -> sec
    function automatic logic [1:0] next_field(input logic [1:0] f);
        return (f == F_HOUR) ? F_SEC : f + 2'd1;
    endfunction

    // One-hot mask of a field index, used to steer inc/dec pulses
    function automatic logic [2:0] field_mask(input logic [1:0] f);
        logic [2:0] m;
        m = 3'b000;
        case (f)
            F_SEC:   m = 3'b001;
            F_MIN:   m = 3'b010;
            F_HOUR:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/auto_repeat_timer.sv
// Hold timer for button auto-repeat. After start, fire pulses once when
// the hold has lasted REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles
// for as long as hold stays high. Dropping hold clears the timer.
module auto_repeat_timer
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic fire
);

    localparam int CW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [CW-1:0] count;
    logic          repeating;

    // The cycle that registers the first pulse loads the count with 1, so
    // the count equals the number of cycles elapsed since that pulse.
    assign fire = hold && !start &&
                  (repeating ? (count == PERIOD_C) : (count == DELAY_C));

    // Count hold cycles; restart from 1 on every fire, clear on release
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            repeating <= 1'b0;
        end else if (start) begin
            count     <= ONE_C;
            repeating <= 1'b0;
        end else if (fire) begin
            count     <= ONE_C;
            repeating <= 1'b1;
        end else if (hold) begin
            count     <= count + ONE_C;
        end else begin
            count     <= '0;
            repeating <= 1'b0;
        end
    end

endmodule

// File: rtl/time_adjust_controller.sv
// Sequencing/arbitration for the seconds/minutes/hours counter bank.
// RUN: converts timebase ticks into increment pulses with carry.
// SET: hands the counters to the buttons with field select and auto-repeat.
module time_adjust_controller
    import clock_pkg::*;
#(
    parameter int W             = 6,
    parameter int LIM0          = DEF_LIM0,
    parameter int LIM1          = DEF_LIM1,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           mode_set,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_next,
    input  logic [3*W-1:0] field_val,
    output logic [2:0]     inc,
    output logic [2:0]     dec,
    output logic [1:0]     sel,
    output logic           set_active
);

    localparam logic [W-1:0] LIM0_C = W'(LIM0);
    localparam logic [W-1:0] LIM1_C = W'(LIM1);

    state_t       state;
    logic         dir_down;
    logic         up_q;
    logic         down_q;
    logic         next_q;

    logic [W-1:0] sec_val;
    logic [W-1:0] min_val;
    logic [W-1:0] hour_unused;

    logic         up_rise;
    logic         down_rise;
    logic         next_rise;
    logic         press_up;
    logic         press_down;
    logic         start;
    logic         held_ok;
    logic         hold;
    logic         fire;
    logic         sec_wrap;
    logic         min_wrap;

    // Hours never generate a carry, so their value is not examined here
    assign sec_val     = field_val[0*W +: W];
    assign min_val     = field_val[1*W +: W];
    assign hour_unused = field_val[2*W +: W];

    assign sec_wrap = (sec_val == LIM0_C);
    assign min_wrap = (min_val == LIM1_C);

    // Rising edges against the previous cycle's button levels
    assign up_rise   = btn_up   && !up_q;
    assign down_rise = btn_down && !down_q;
    assign next_rise = btn_next && !next_q;

    // A press only counts when the opposite button is released
    assign press_up   = (state == S_SET_IDLE) && mode_set && up_rise   && !btn_down;
    assign press_down = (state == S_SET_IDLE) && mode_set && down_rise && !btn_up;
    assign start      = press_up || press_down;

    // Holding continues only while the active button alone stays pressed
    assign held_ok = dir_down ? (btn_down && !btn_up) : (btn_up && !btn_down);
    assign hold    = ((state == S_SET_HOLD) || (state == S_SET_REPEAT)) &&
                     mode_set && held_ok;

    assign set_active = (state != S_RUN);

    auto_repeat_timer #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .hold  (hold),
        .fire  (fire)
    );

    // Register button levels for edge detection in every mode, so a button
    // already held when SET mode is entered shows no edge
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            next_q <= 1'b0;
        end else begin
            up_q   <= btn_up;
            down_q <= btn_down;
            next_q <= btn_next;
        end
    end

    // Mode FSM with registered, single-cycle inc/dec pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RUN;
            sel      <= F_SEC;
            dir_down <= 1'b0;
            inc      <= 3'b000;
            dec      <= 3'b000;
        end else begin
            inc <= 3'b000;
            dec <= 3'b000;
            case (state)
                S_RUN: begin
                    // A tick in the cycle mode_set rises is still honoured
                    inc <= {tick && sec_wrap && min_wrap, tick && sec_wrap, tick};
                    if (mode_set) begin
                        state <= S_SET_IDLE;
                        sel   <= F_SEC;
                    end
                end
                S_SET_IDLE: begin
                    if (!mode_set) begin
                        state <= S_RUN;
                    end else if (start) begin
                        state    <= S_SET_HOLD;
                        dir_down <= press_down;
                        if (press_up) begin
                            inc <= field_mask(sel);
                        end else begin
                            dec <= field_mask(sel);
                        end
                    end else if (next_rise) begin
                        sel <= next_field(sel);
                    end
                end
                S_SET_HOLD, S_SET_REPEAT: begin
                    if (!mode_set) begin
                        state <= S_RUN;
                    end else if (!hold) begin
                        state <= S_SET_IDLE;
                    end else if (fire) begin
                        state <= S_SET_REPEAT;
                        if (dir_down) begin
                            dec <= field_mask(sel);
                        end else begin
                            inc <= field_mask(sel);
                        end
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_adjust_controller.sv
// Directed bench for time_adjust_controller with REPEAT_DELAY = 8 and
// REPEAT_PERIOD = 4; expected values are hand-computed per stimulus step.
module tb_time_adjust_controller;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick;
    logic           mode_set;
    logic           btn_up;
    logic           btn_down;
    logic           btn_next;
    logic [3*W-1:0] field_val;
    logic [2:0]     inc;
    logic [2:0]     dec;
    logic [1:0]     sel;
    logic           set_active;

    int n_pass  = 0;
    int n_total = 0;

    time_adjust_controller #(
        .W             (W),
        .LIM0          (59),
        .LIM1          (59),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .mode_set   (mode_set),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_next   (btn_next),
        .field_val  (field_val),
        .inc        (inc),
        .dec        (dec),
        .sel        (sel),
        .set_active (set_active)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] acc_inc;
    logic [2:0] acc_dec;

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        mode_set  = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_next  = 1'b0;
        field_val = {6'd0, 6'd0, 6'd0};
        step();
        step();
        check("rst_inc", inc, 0);
        check("rst_dec", dec, 0);
        check("rst_sel", sel, 0);
        check("rst_set_active", set_active, 0);
        reset = 1'b0;
        step();

        // RUN carry: 5:59:59 -> all three fields increment
        field_val = {6'd5, 6'd59, 6'd59};
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("carry_all_inc", inc, 3'b111);
        check("carry_all_dec", dec, 0);
        step();
        check("carry_pulse_end", inc, 0);
        field_val = {6'd5, 6'd59, 6'd10};
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("carry_none_inc", inc, 3'b001);
        step();
        field_val = {6'd5, 6'd10, 6'd59};
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("carry_min_inc", inc, 3'b011);
        step();

        // Buttons are ignored in RUN
        btn_up = 1'b1;
        step();
        check("run_btn_inc", inc, 0);
        btn_up = 1'b0;
        step();

        // Enter SET, then cycle the field select
        mode_set = 1'b1;
        step();
        check("set_active_rise", set_active, 1);
        check("set_sel0", sel, 0);
        for (int i = 0; i < 4; i++) begin
            btn_next = 1'b1;
            step();
            check("sel_step", sel, (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 0 : 1);
            btn_next = 1'b0;
            step();
        end

        // Auto-repeat on minutes: pulses at hold cycles 1, 9, 13, 17
        btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("rep_inc", inc,
                  (i == 1 || i == 9 || i == 13 || i == 17) ? 3'b010 : 3'b000);
            check("rep_dec", dec, 0);
        end
        btn_up = 1'b0;
        step();
        check("rep_release_inc", inc, 0);
        step();

        // Both buttons together: no pulse
        btn_up   = 1'b1;
        btn_down = 1'b1;
        step();
        check("both_inc", inc, 0);
        check("both_dec", dec, 0);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step();

        // Down press on selected field gives one dec pulse
        btn_down = 1'b1;
        step();
        check("down_dec", dec, 3'b010);
        check("down_inc", inc, 0);
        btn_down = 1'b0;
        step();

        // Opposite button during an up hold stops the repeat
        btn_up = 1'b1;
        step();
        check("hold_first_inc", inc, 3'b010);
        btn_down = 1'b1;
        acc_inc  = 3'b000;
        acc_dec  = 3'b000;
        for (int i = 0; i < 12; i++) begin
            step();
            acc_inc = acc_inc | inc;
            acc_dec = acc_dec | dec;
        end
        check("conflict_inc", acc_inc, 0);
        check("conflict_dec", acc_dec, 0);
        btn_down = 1'b0;
        step();
        check("conflict_release_inc", inc, 0);
        btn_up = 1'b0;
        step();

        // Tick is dropped in SET mode
        field_val = {6'd5, 6'd59, 6'd59};
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("set_tick_inc", inc, 0);
        step();

        // Dropping mode_set mid-repeat: no pulse, RUN ticks resume
        btn_up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("drop_rep_inc", inc, (i == 1 || i == 9) ? 3'b010 : 3'b000);
        end
        mode_set = 1'b0;
        step();
        check("drop_inc", inc, 0);
        check("drop_dec", dec, 0);
        check("drop_set_active", set_active, 0);
        btn_up    = 1'b0;
        field_val = {6'd5, 6'd59, 6'd10};
        tick      = 1'b1;
        step();
        tick = 1'b0;
        check("resume_inc", inc, 3'b001);
        step();

        // mode_set rising in a tick cycle: the tick is honoured
        field_val = {6'd5, 6'd59, 6'd59};
        mode_set  = 1'b1;
        tick      = 1'b1;
        step();
        tick = 1'b0;
        check("mode_tick_inc", inc, 3'b111);
        check("mode_tick_set_active", set_active, 1);
        check("mode_tick_sel", sel, 0);
        step();

        // Reset during SET_REPEAT on seconds
        btn_up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("rst_rep_inc", inc, (i == 1 || i == 9) ? 3'b001 : 3'b000);
        end
        reset = 1'b1;
        step();
        check("midrst_inc", inc, 0);
        check("midrst_dec", dec, 0);
        check("midrst_sel", sel, 0);
        check("midrst_set_active", set_active, 0);
        reset    = 1'b0;
        mode_set = 1'b0;
        btn_up   = 1'b0;
        step();
        check("post_rst_set_active", set_active, 0);
        field_val = {6'd5, 6'd59, 6'd10};
        tick      = 1'b1;
        step();
        tick = 1'b0;
        check("post_rst_tick_inc", inc, 3'b001);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/time_adjust_controller.md
# time_adjust_controller

Sequencing and arbitration controller for the three-field clock counter bank: seconds (field 0), minutes (field 1) and hours (field 2). Each field is an up/down counter that wraps at its own modulus and is edge-triggered on separate up and down request lines. In RUN mode this block turns the timebase tick into increment pulses, including the seconds→minutes→hours carry. In SET mode it gives the counter bank to the user buttons, with field selection and auto-repeat.

## Interface
- `W`, 6: width of each field value.
- `LIM0`, 59: terminal value of field 0 (seconds); a carry is generated when a tick arrives at this value.
- `LIM1`, 59: terminal value of field 1 (minutes).
- `REPEAT_DELAY`, 25_000_000: hold cycles from the first pulse to the first repeat pulse.
- `REPEAT_PERIOD`, 5_000_000: cycles between repeat pulses; must be ≥2.

- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `tick`  in  1  timebase pulse, one cycle wide, at least 2 cycles apart.
- `mode_set`  in  1  level; 1 = SET mode, 0 = RUN mode.
- `btn_up`, `btn_down`, `btn_next`  in  1 each  levels, already debounced and synchronized.
- `field_val`  in  3*W  current counter values, field k at bits [k*W +: W].
- `inc`  out  3  per-field increment pulses, registered.
- `dec`  out  3  per-field decrement pulses, registered.
- `sel`  out  2  field selected for adjustment (0..2).
- `set_active`  out  1  high while the FSM is in any SET state.

## Operation
- **States:** RUN, SET_IDLE, SET_HOLD, SET_REPEAT.
- **RUN:**
  - On `tick`: `inc[0]` = 1.
  - `inc[1]` = 1 when `field_val[0]` == LIM0.
  - `inc[2]` = 1 when `field_val[0]` == LIM0 and `field_val[1]` == LIM1.
  - All carry pulses fire in the same cycle. `dec` is always 0.
  - Buttons are ignored.
- **RUN → SET_IDLE:** when `mode_set` = 1. `sel` is loaded with 0.
- **Any SET state → RUN:** when `mode_set` = 0. Takes effect on the next edge; no further pulses are issued.
- **SET mode ticks:** `tick` is dropped, not queued. The user owns the counter bank.
- **SET_IDLE:**
  - A rising edge of `btn_next` advances `sel` 0→1→2→0.
  - A rising edge of `btn_up` with `btn_down` low gives one `inc[sel]` pulse, then → SET_HOLD. The down direction is symmetric and uses `dec[sel]`.
  - Both `btn_up` and `btn_down` high: no pulse, stay in SET_IDLE.
- **SET_HOLD:**
  - The repeat counter counts while the active button is held.
  - When it reaches REPEAT_DELAY: one pulse, → SET_REPEAT.
  - Button released, or the other button pressed: → SET_IDLE, counter cleared.
- **SET_REPEAT:** one pulse every REPEAT_PERIOD cycles while held. Release or the opposite button: → SET_IDLE.
- **`btn_next` during HOLD/REPEAT:** ignored. `sel` is stable while a button is held.
- **No carry in SET mode:** user adjustments never carry or borrow between fields. Wrap-around is handled inside each counter.
- **Pulse width:** every `inc`/`dec` pulse is exactly 1 cycle, with at least 1 low cycle before the next pulse on the same line. The counters detect edges and need the release cycle.

## Timing
- **Reset values:** `inc` = 0, `dec` = 0, `sel` = 0, `set_active` = 0, state RUN, repeat counter 0.
- **Reset mid-operation:** all outputs return to reset values on the next edge, including mid-hold or mid-carry.
- **Latency:** exactly 1 cycle from the input event (`tick`, button rising edge, counter terminal count) to the output pulse.
- **`set_active`:** high 1 cycle after `mode_set` rises; low 1 cycle after it falls.
- **Edge detection:** button rising edges are detected against values registered in the previous cycle. A button already held when SET mode is entered produces no pulse until it is released and pressed again.
- **Carry decision:** uses `field_val` as sampled in the `tick` cycle.
- **Mode change on a tick cycle:** `mode_set` rising in the same cycle as `tick` means RUN is still active in that cycle, so the tick is honoured.

## Structure
- **Shared package** (`clock_pkg`):
  - state enum;
  - field index constants `F_SEC` = 0, `F_MIN` = 1, `F_HOUR` = 2;
  - default limits 59/59/23;
  - repeat-timing defaults.
- **Sub-module `auto_repeat_timer`:**
  - Inputs: `start`, `hold`.
  - Output: `fire`, one pulse at REPEAT_DELAY then every REPEAT_PERIOD.
  - Counter width is $clog2(REPEAT_DELAY+1).
  - Instantiated once and shared by both directions.

## Test plan
All cases use REPEAT_DELAY = 8 and REPEAT_PERIOD = 4.
- **RUN carry:** `field_val` = {h=5, m=59, s=59}, `tick` → next cycle `inc` = 3'b111, `dec` = 0; with s=10, `inc` = 3'b001.
- **Field select:** `mode_set` = 1, `btn_next` pulsed 4 times → `sel` sequence 1, 2, 0, 1; `set_active` = 1 one cycle after `mode_set`.
- **Auto-repeat:** with `sel` = 1, hold `btn_up` for 20 cycles → `inc[1]` pulses at hold cycles 1, 9, 13, 17; `inc[0]`, `inc[2]` and `dec` stay 0.
- **Conflicting buttons:** `btn_up` and `btn_down` pressed together → no pulses. Pressing `btn_down` during an `btn_up` hold → repeat stops, returns to SET_IDLE.
- **SET mode tick suppression:** `tick` while in SET mode → `inc` = 0. Dropping `mode_set` mid-repeat → no pulse after the next edge, and RUN ticks resume.
- **Reset mid-operation:** `reset` asserted during SET_REPEAT → next cycle all outputs 0, `sel` = 0, state RUN.
